// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: PC step, default address width,
// the prediction shadow-slot layout and the resolved-control-kind encoding.
package mips_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned PC_STEP       = 4;

  // Which resolved source supplies the actual target, in legacy priority order.
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_BRANCH = 2'd1,
    RES_JR     = 2'd2,
    RES_JUMP   = 2'd3
  } res_kind_t;

  typedef struct packed {
    logic                     valid;
    logic                     pred_taken;
    logic [DEFAULT_WIDTH-1:0] pred_target;
    logic [DEFAULT_WIDTH-1:0] pc;
  } pred_slot_t;

endpackage

// File: rtl/pred_shadow_pipe.sv
// Shift register carrying each fetch's prediction down to the resolve stage.
// A flush invalidates every slot and takes priority over a stall.
module pred_shadow_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             fetch_taken,
  input  logic [WIDTH-1:0] fetch_target,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             res_valid,
  output logic             res_pred_taken,
  output logic [WIDTH-1:0] res_pred_target,
  output logic [WIDTH-1:0] res_pc
);

  logic             valid_q  [DEPTH];
  logic             taken_q  [DEPTH];
  logic [WIDTH-1:0] target_q [DEPTH];
  logic [WIDTH-1:0] pc_q     [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        taken_q[i]  <= 1'b0;
        target_q[i] <= '0;
        pc_q[i]     <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0]  <= 1'b1;
      taken_q[0]  <= fetch_taken;
      target_q[0] <= fetch_target;
      pc_q[0]     <= fetch_pc;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i]  <= valid_q[i-1];
        taken_q[i]  <= taken_q[i-1];
        target_q[i] <= target_q[i-1];
        pc_q[i]     <= pc_q[i-1];
      end
    end
  end

  assign res_valid       = valid_q[DEPTH-1];
  assign res_pred_taken  = taken_q[DEPTH-1];
  assign res_pred_target = target_q[DEPTH-1];
  assign res_pc          = pc_q[DEPTH-1];

endmodule

// File: rtl/next_pc_unit.sv
// Registered next-PC generator: follows BTB predictions, checks them at the
// resolve stage, and on a mismatch redirects, flushes and retrains the BTB.
module next_pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH         = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned      RESOLVE_DEPTH = 2,
  parameter int unsigned      CNT_WIDTH     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Stall,
  input  logic                 BtbHit,
  input  logic [WIDTH-1:0]     BtbTarget,
  input  logic                 ResValid,
  input  logic                 ResBranch,
  input  logic                 ResTaken,
  input  logic                 ResJr,
  input  logic                 ResJump,
  input  logic [WIDTH-1:0]     BranchAddress,
  input  logic [WIDTH-1:0]     JrAddress,
  input  logic [WIDTH-1:0]     JumpAddress,
  output logic [WIDTH-1:0]     PC,
  output logic [WIDTH-1:0]     PCPlus4,
  output logic                 Flush,
  output logic                 BtbUpdate,
  output logic [WIDTH-1:0]     BtbUpdatePC,
  output logic                 BtbUpdateTaken,
  output logic [WIDTH-1:0]     BtbUpdateTarget,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  logic             s_valid;
  logic             s_pred_taken;
  logic [WIDTH-1:0] s_pred_target;
  logic [WIDTH-1:0] s_pc;

  res_kind_t        res_kind;
  logic             act_taken;
  logic [WIDTH-1:0] act_target;
  logic [WIDTH-1:0] corr_pc;
  logic             mispredict;

  pred_shadow_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (RESOLVE_DEPTH)
  ) u_shadow (
    .clk             (Clk),
    .rst             (Rst),
    .stall           (Stall),
    .flush           (mispredict),
    .fetch_taken     (BtbHit),
    .fetch_target    (BtbTarget),
    .fetch_pc        (PC),
    .res_valid       (s_valid),
    .res_pred_taken  (s_pred_taken),
    .res_pred_target (s_pred_target),
    .res_pc          (s_pc)
  );

  // Classify the resolved instruction; a taken branch outranks jr, jr outranks j/jal.
  always_comb begin
    res_kind = RES_NONE;
    if (ResValid) begin
      if (ResBranch && ResTaken) res_kind = RES_BRANCH;
      else if (ResJr)            res_kind = RES_JR;
      else if (ResJump)          res_kind = RES_JUMP;
    end
  end

  always_comb begin
    act_target = JumpAddress;
    unique case (res_kind)
      RES_BRANCH: act_target = BranchAddress;
      RES_JR:     act_target = JrAddress;
      default:    act_target = JumpAddress;
    endcase
  end

  assign act_taken  = (res_kind != RES_NONE);
  assign corr_pc    = act_taken ? act_target : s_pc + WIDTH'(PC_STEP);
  assign mispredict = s_valid &&
                      ((s_pred_taken != act_taken) ||
                       (act_taken && (s_pred_target != act_target)));

  assign PCPlus4         = PC + WIDTH'(PC_STEP);
  assign Flush           = mispredict;
  assign BtbUpdate       = s_valid && ((ResValid && !Stall) || mispredict);
  assign BtbUpdatePC     = s_pc;
  assign BtbUpdateTaken  = act_taken;
  assign BtbUpdateTarget = corr_pc;

  // Redirect wins over stall; otherwise follow the BTB or fall through.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      PC <= RESET_PC;
    end else if (mispredict) begin
      PC <= corr_pc;
    end else if (!Stall) begin
      PC <= BtbHit ? BtbTarget : PCPlus4;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      MispredictCount <= '0;
    end else if (mispredict && (MispredictCount != {CNT_WIDTH{1'b1}})) begin
      MispredictCount <= MispredictCount + CNT_WIDTH'(1);
    end
  end

endmodule
